mux_scan_ctrl: RTL and testbench
================================

Name: mux_scan_ctrl

Overview:
Upstream channel-scan sequencer for the 4:1 mux (mux_4_1). It drives sel0/sel1 through the enabled channels, dwells a programmable number of cycles per channel and captures the mux output y on each channel. It then publishes one 4-bit frame of samples with a single-cycle valid strobe. It supports single-shot and continuous scanning and can be aborted mid-frame.

Parameters:
DWELL, 4, cycles spent on each enabled channel; legal range 1..255.
CNT_W, 8, dwell counter width; must hold DWELL-1.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request one scan frame; level-sampled, acted on only in IDLE
stop  input  1  abort the current scan; return to IDLE
cont  input  1  continuous mode; sampled at frame end
ch_mask  input  4  channel enable, bit n = channel n; latched at start
y_in  input  1  mux output y, fed back from mux_4_1
sel0  output  1  mux select LSB
sel1  output  1  mux select MSB
sample  output  4  last completed frame; bit n = y on channel n; disabled channels read 0
sample_valid  output  1  one-cycle strobe when sample updates
busy  output  1  high while a frame is in progress

Behaviour:
- Channel encoding: channel n is selected when {sel1,sel0} = n.
- Reset (rst high at a clk edge): state IDLE, sel0=sel1=0, sample=0, sample_valid=0, busy=0, shadow register=0, counter=0. Reset takes priority over every other input, including mid-frame.
- States:
  - IDLE: sel=00, busy=0.
  - SCAN: busy=1, sel = current channel, counter runs.
  - DONE: a single cycle, not externally visible as a state.
- IDLE -> SCAN:
  - Requires start=1, stop=0 and ch_mask != 0 at edge E0.
  - At E0: mask is latched, current channel = lowest enabled channel, counter=0, shadow=0.
  - After E0: busy=1 and sel shows that channel.
  - start with ch_mask=0 is ignored and the block stays IDLE.
- SCAN:
  - The counter increments each cycle.
  - At the edge where counter==DWELL-1:
    - y_in is captured into shadow[current channel];
    - the counter clears;
    - current channel advances to the next higher enabled channel in the latched mask.
  - If no higher enabled channel remains, the frame ends.
- Frame end, at the capture edge of the last channel:
  - sample <= shadow, including that final capture.
  - sample_valid=1 for exactly the following cycle.
  - If cont=1, a new frame starts on the same edge with the latched mask: sel jumps to the lowest enabled channel, busy stays 1, shadow clears.
  - If cont=0, the block goes to IDLE: busy=0, sel=00.
- Timing: with N enabled channels, the frame's sample_valid is high in the cycle after edge E0 + N*DWELL. Channel k of the frame occupies cycles E0+k*DWELL+1 .. E0+(k+1)*DWELL.
- stop=1 in SCAN:
  - At that edge the block enters IDLE: busy=0, sel=00.
  - The shadow is discarded, sample holds its previous value and there is no sample_valid.
  - stop coinciding with a frame-end edge wins: no update, no strobe.
- start while busy is ignored. ch_mask changes during SCAN are ignored until the next start.
- start and stop together in IDLE: stop wins and the block stays IDLE.
- sample_valid is never high for two consecutive cycles, except in continuous mode when DWELL=1 and N=1, where it is high every cycle.

Optional Feature:
MUX_SCAN_PARITY_EN
- Defined: adds output sample_parity (1 bit). It is registered together with sample and equals the XOR of the new sample bits. It resets to 0 and is updated only on frame-end edges.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
1. DWELL=4, mask=1111, mux inputs {i3,i2,i1,i0}=1010, pulse start -> sel 00,01,10,11 for 4 cycles each; sample_valid high in the cycle after E0+16; sample=1010; busy falls at the same edge; sel returns to 00.
2. mask=0101, inputs=1111 -> only channels 0 and 2 visited, 4 cycles each; sample=0101 with valid after E0+8.
3. Full scan with sample previously 1010, stop asserted at edge E0+6 -> busy=0 and sel=00 after that edge; no sample_valid; sample stays 1010.
4. cont=1, mask=0011, inputs 0001 then 0010 applied between frames -> sample_valid every 8 cycles; samples 0001 then 0010; busy never drops. Deassert cont -> the block goes IDLE after the current frame.
5. start with mask=0000 -> no activity. start while busy -> no restart. rst asserted at E0+5 -> all outputs zero after that edge; start in the next cycle then behaves as in scenario 1.
6. With MUX_SCAN_PARITY_EN defined: frame result 1011 -> sample_parity=1; frame result 0110 -> sample_parity=0, aligned with sample_valid.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - channel-scan sequencer driving a 4:1 mux and framing its samples
//
// Optional feature macro: MUX_SCAN_PARITY_EN (adds sample_parity output)
//
// Parameters:
//   DWELL        cycles spent on each enabled channel (1..255)
//   CNT_W        dwell counter width, must hold DWELL-1
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   start         in   request a scan frame (acted on only when idle)
//   stop          in   abort the current scan
//   cont          in   continuous mode, sampled at frame end
//   ch_mask[3:0]  in   channel enables, latched at start
//   y_in          in   mux output fed back from the mux
//   sel0, sel1    out  mux select, {sel1,sel0} = channel
//   sample[3:0]   out  last completed frame, disabled channels read 0
//   sample_valid  out  one-cycle strobe when sample updates
//   busy          out  high while a frame is in progress
//   sample_parity out  XOR of sample bits (only with MUX_SCAN_PARITY_EN)

module mux_scan_ctrl #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       cont,
  input  logic [3:0] ch_mask,
  input  logic       y_in,
  output logic       sel0,
  output logic       sel1,
  output logic [3:0] sample,
  output logic       sample_valid,
  output logic       busy
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic       sample_parity
`endif
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL - 1);

  state_t           state_q, state_d;
  logic [3:0]       mask_q, mask_d;
  logic [1:0]       ch_q, ch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       shadow_q, shadow_d;
  logic [3:0]       sample_q, sample_d;
  logic             valid_q, valid_d;
`ifdef MUX_SCAN_PARITY_EN
  logic             parity_q, parity_d;
`endif

  // Shadow with the current channel's capture merged in; used at every capture edge.
  logic [3:0]       captured;
  // {found, channel} of the next higher enabled channel above ch_q.
  logic [2:0]       nxt;

  function automatic logic [1:0] lowest_ch(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) r = 2'(i);
    end
    return r;
  endfunction

  function automatic logic [2:0] next_ch(input logic [3:0] m, input logic [1:0] cur);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && (2'(i) > cur)) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mask_q   <= 4'b0000;
      ch_q     <= 2'd0;
      cnt_q    <= '0;
      shadow_q <= 4'b0000;
      sample_q <= 4'b0000;
      valid_q  <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
`ifdef MUX_SCAN_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
`ifdef MUX_SCAN_PARITY_EN
    parity_d = parity_q;
`endif
    captured       = shadow_q;
    captured[ch_q] = y_in;
    nxt            = next_ch(mask_q, ch_q);

    case (state_q)
      S_IDLE: begin
        // stop has priority over start; an empty mask is not a frame.
        if (start && !stop && (ch_mask != 4'b0000)) begin
          state_d  = S_SCAN;
          mask_d   = ch_mask;
          ch_d     = lowest_ch(ch_mask);
          cnt_d    = '0;
          shadow_d = 4'b0000;
        end
      end
      S_SCAN: begin
        if (stop) begin
          // Abort discards the partial frame; sample keeps its old value.
          state_d  = S_IDLE;
          ch_d     = 2'd0;
          cnt_d    = '0;
          shadow_d = 4'b0000;
        end else if (cnt_q == DWELL_M1) begin
          cnt_d = '0;
          if (nxt[2]) begin
            ch_d     = nxt[1:0];
            shadow_d = captured;
          end else begin
            // Frame end: publish including the capture made on this edge.
            sample_d = captured;
            valid_d  = 1'b1;
`ifdef MUX_SCAN_PARITY_EN
            parity_d = ^captured;
`endif
            shadow_d = 4'b0000;
            if (cont) begin
              ch_d = lowest_ch(mask_q);
            end else begin
              state_d = S_IDLE;
              ch_d    = 2'd0;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == S_SCAN);
    sel0 = busy ? ch_q[0] : 1'b0;
    sel1 = busy ? ch_q[1] : 1'b0;
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
`ifdef MUX_SCAN_PARITY_EN
  assign sample_parity = parity_q;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - self-checking bench for mux_scan_ctrl with a frame-level reference model

module tb_mux_scan_ctrl;

  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       cont;
  logic [3:0] ch_mask;
  logic [3:0] mux_in;
  logic       y_in;
  logic       sel0;
  logic       sel1;
  logic [3:0] sample;
  logic       sample_valid;
  logic       busy;
`ifdef MUX_SCAN_PARITY_EN
  logic       sample_parity;
`endif

  mux_scan_ctrl #(.DWELL(DWELL), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .cont         (cont),
    .ch_mask      (ch_mask),
    .y_in         (y_in),
    .sel0         (sel0),
    .sel1         (sel1),
    .sample       (sample),
    .sample_valid (sample_valid),
    .busy         (busy)
`ifdef MUX_SCAN_PARITY_EN
    ,
    .sample_parity(sample_parity)
`endif
  );

  always #5 clk = ~clk;

  // The 4:1 mux being scanned.
  assign y_in = mux_in[{sel1, sel0}];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of enabled channels and an edge count t since E0.
  bit         m_active = 1'b0;
  int         m_t      = 0;
  int         m_list[4];
  int         m_n      = 0;
  int         m_k      = 0;
  logic [3:0] m_shadow = 4'b0000;
  logic [3:0] m_sample = 4'b0000;
  bit         m_valid  = 1'b0;
  bit         m_par    = 1'b0;

  always @(posedge clk) begin
    m_valid = 1'b0;
    if (rst) begin
      m_active = 1'b0;
      m_sample = 4'b0000;
      m_par    = 1'b0;
    end else if (!m_active) begin
      if (start && !stop && ch_mask != 4'b0000) begin
        m_n = 0;
        for (int i = 0; i < 4; i++) begin
          if (ch_mask[i]) begin
            m_list[m_n] = i;
            m_n++;
          end
        end
        m_active = 1'b1;
        m_t      = 0;
        m_shadow = 4'b0000;
      end
    end else if (stop) begin
      m_active = 1'b0;
    end else begin
      m_t++;
      if (m_t % DWELL == 0) begin
        m_k = m_t / DWELL - 1;
        m_shadow[m_list[m_k]] = mux_in[m_list[m_k]];
        if (m_k == m_n - 1) begin
          m_sample = m_shadow;
          m_par    = ^m_shadow;
          m_valid  = 1'b1;
          if (cont) begin
            m_t      = 0;
            m_shadow = 4'b0000;
          end else begin
            m_active = 1'b0;
          end
        end
      end
    end
  end

  // Compare process: every cycle after the first reset.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'b0, busy}, {31'b0, m_active});
      chk("sel", {30'b0, sel1, sel0}, m_active ? m_list[m_t / DWELL] : 0);
      chk("sample", {28'b0, sample}, {28'b0, m_sample});
      chk("sample_valid", {31'b0, sample_valid}, {31'b0, m_valid});
`ifdef MUX_SCAN_PARITY_EN
      chk("sample_parity", {31'b0, sample_parity}, {31'b0, m_par});
`endif
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start(input logic [3:0] m);
    ch_mask = m;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  // Ticks at least once, stops on the cycle sample_valid is seen; n counts cycles.
  task automatic wait_valid(input int n0, output int n);
    n = n0;
    do begin
      tick();
      n++;
    end while (!sample_valid && n < 300);
  endtask

  int n;

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0;
    ch_mask = 4'b0000; mux_in = 4'b0000;
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_sample", {28'b0, sample}, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_sel", {30'b0, sel1, sel0}, 32'h0);

    // Sparse mask: only channels 0 and 2.
    mux_in = 4'b1111;
    pulse_start(4'b0101);
    chk("s2_sel_first", {30'b0, sel1, sel0}, 32'd0);
    wait_valid(1, n);
    chk("s2_latency", n, 32'd9);
    chk("s2_sample", {28'b0, sample}, 32'b0101);

    // Full scan.
    tick();
    mux_in = 4'b1010;
    pulse_start(4'b1111);
    chk("s1_busy", {31'b0, busy}, 32'd1);
    wait_valid(1, n);
    chk("s1_latency", n, 32'd17);
    chk("s1_sample", {28'b0, sample}, 32'b1010);
    chk("s1_busy_end", {31'b0, busy}, 32'd0);

    // Abort at E0+6.
    mux_in = 4'b0101;
    pulse_start(4'b1111);
    repeat (5) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("s3_busy", {31'b0, busy}, 32'd0);
    chk("s3_sel", {30'b0, sel1, sel0}, 32'd0);
    repeat (20) tick();
    chk("s3_sample_kept", {28'b0, sample}, 32'b1010);

    // Continuous mode.
    cont   = 1'b1;
    mux_in = 4'b0001;
    pulse_start(4'b0011);
    wait_valid(1, n);
    chk("s4_latency", n, 32'd9);
    chk("s4_sample0", {28'b0, sample}, 32'b0001);
    mux_in = 4'b0010;
    wait_valid(0, n);
    chk("s4_period", n, 32'd8);
    chk("s4_sample1", {28'b0, sample}, 32'b0010);
    chk("s4_busy", {31'b0, busy}, 32'd1);
    cont = 1'b0;
    wait_valid(0, n);
    chk("s4_last_period", n, 32'd8);
    chk("s4_idle", {31'b0, busy}, 32'd0);

    // Empty mask, start while busy, reset mid-frame.
    tick();
    pulse_start(4'b0000);
    chk("s5_empty_mask", {31'b0, busy}, 32'd0);
    mux_in = 4'b0110;
    pulse_start(4'b1111);
    repeat (2) tick();
    ch_mask = 4'b0001;
    start = 1'b1;
    repeat (2) tick();
    start = 1'b0;
    wait_valid(5, n);
    chk("s5_no_restart_latency", n, 32'd17);
    chk("s5_sample", {28'b0, sample}, 32'b0110);
    tick();
    pulse_start(4'b1111);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s5_rst_sample", {28'b0, sample}, 32'h0);
    chk("s5_rst_busy", {31'b0, busy}, 32'h0);
    chk("s5_rst_sel", {30'b0, sel1, sel0}, 32'h0);
    mux_in = 4'b1010;
    pulse_start(4'b1111);
    wait_valid(1, n);
    chk("s5_after_rst_latency", n, 32'd17);
    chk("s5_after_rst_sample", {28'b0, sample}, 32'b1010);

`ifdef MUX_SCAN_PARITY_EN
    mux_in = 4'b1011;
    pulse_start(4'b1111);
    wait_valid(1, n);
    chk("s6_parity_1011", {31'b0, sample_parity}, 32'd1);
    mux_in = 4'b0110;
    pulse_start(4'b1111);
    wait_valid(1, n);
    chk("s6_parity_0110", {31'b0, sample_parity}, 32'd0);
`endif

    // Randomized traffic checked by the compare process.
    for (int c = 0; c < 4000; c++) begin
      rst     = ($urandom % 300) == 0;
      start   = ($urandom % 4) == 0;
      stop    = ($urandom % 50) == 0;
      cont    = ($urandom % 3) != 0;
      ch_mask = 4'($urandom);
      mux_in  = 4'($urandom);
      tick();
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0; cont = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
